// File: rtl/input_menu.sv
// ---------------------------------------------------------------------------
// input_menu
//
// Purpose:
//   Button-driven data-entry front end for the 8-slot display path. A slot
//   cursor is walked with prev/next; the edit button loads the selected slot
//   into a draft that is then changed one hex nibble at a time. Commit writes
//   the draft back into the selected slot register. The eight slot registers
//   feed the selectable inputs of the output-selection menu.
//
// Ports:
//   clk       in   system clock, all logic on posedge
//   rst       in   synchronous reset, active-low
//   button    in   [3:0] debounced levels: [0] prev/dec, [1] next/inc,
//                  [2] edit/digit-advance, [3] commit
//   out0..7   out  [WIDTH-1:0] slot registers
//   position  out  [2:0] slot cursor
//   editing   out  1 while in the EDIT state
//   digit     out  [2:0] nibble index being edited, 0 = LSB nibble
//   draft     out  [WIDTH-1:0] working value shown while editing
//   wr_valid  out  one-cycle pulse on commit
//   wr_slot   out  [2:0] slot written, valid while wr_valid = 1
//
// Configuration:
//   INPUT_MENU_CANCEL_EN  when defined, edit+commit pressed in the same cycle
//                         while editing abandons the edit without writing.
//                         When undefined, that combination is a plain commit.
// ---------------------------------------------------------------------------
module input_menu #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       button,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [WIDTH-1:0] out4,
    output logic [WIDTH-1:0] out5,
    output logic [WIDTH-1:0] out6,
    output logic [WIDTH-1:0] out7,
    output logic [2:0]       position,
    output logic             editing,
    output logic [2:0]       digit,
    output logic [WIDTH-1:0] draft,
    output logic             wr_valid,
    output logic [2:0]       wr_slot
);

    localparam int NDIG = WIDTH / 4;

    typedef enum logic {
        BROWSE,
        EDIT
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       btn_q;
    logic [3:0]       btn_edge;
    logic [2:0]       position_q, position_d;
    logic [2:0]       digit_q, digit_d;
    logic [WIDTH-1:0] draft_q, draft_d;
    logic             wr_valid_q, wr_valid_d;
    logic [2:0]       wr_slot_q, wr_slot_d;
    logic [WIDTH-1:0] slot_q [8];
    logic [WIDTH-1:0] slot_d [8];

    // Next-state logic. Only rising edges act, so a held button never repeats.
    always_comb begin
        btn_edge   = button & ~btn_q;
        state_d    = state_q;
        position_d = position_q;
        digit_d    = digit_q;
        draft_d    = draft_q;
        wr_valid_d = 1'b0;
        wr_slot_d  = wr_slot_q;
        slot_d     = slot_q;

        case (state_q)
            BROWSE: begin
                // Entering edit wins over a cursor move in the same cycle.
                if (btn_edge[2]) begin
                    state_d = EDIT;
                    draft_d = slot_q[position_q];
                    digit_d = 3'd0;
                end else if (btn_edge[0] && !btn_edge[1]) begin
                    position_d = position_q - 3'd1;
                end else if (btn_edge[1] && !btn_edge[0]) begin
                    position_d = position_q + 3'd1;
                end
            end

            EDIT: begin
`ifdef INPUT_MENU_CANCEL_EN
                if (btn_edge[3] && btn_edge[2]) begin
                    state_d = BROWSE;
                end else
`endif
                if (btn_edge[3]) begin
                    slot_d[position_q] = draft_q;
                    wr_valid_d         = 1'b1;
                    wr_slot_d          = position_q;
                    state_d            = BROWSE;
                end else if (btn_edge[2]) begin
                    if (digit_q == 3'(NDIG - 1)) begin
                        digit_d = 3'd0;
                    end else begin
                        digit_d = digit_q + 3'd1;
                    end
                end else if (btn_edge[0] != btn_edge[1]) begin
                    // Each nibble wraps on its own; no carry or borrow leaks
                    // into the neighbouring nibble.
                    for (int i = 0; i < NDIG; i++) begin
                        if (digit_q == 3'(i)) begin
                            if (btn_edge[0]) begin
                                draft_d[4*i +: 4] = draft_q[4*i +: 4] - 4'd1;
                            end else begin
                                draft_d[4*i +: 4] = draft_q[4*i +: 4] + 4'd1;
                            end
                        end
                    end
                end
            end

            default: state_d = BROWSE;
        endcase
    end

    // State registers. btn_q resets to all-ones so buttons held through
    // reset must be released and pressed again before they act.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= BROWSE;
            btn_q      <= 4'b1111;
            position_q <= 3'd0;
            digit_q    <= 3'd0;
            draft_q    <= '0;
            wr_valid_q <= 1'b0;
            wr_slot_q  <= 3'd0;
            for (int i = 0; i < 8; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            btn_q      <= button;
            position_q <= position_d;
            digit_q    <= digit_d;
            draft_q    <= draft_d;
            wr_valid_q <= wr_valid_d;
            wr_slot_q  <= wr_slot_d;
            for (int i = 0; i < 8; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

    assign out0     = slot_q[0];
    assign out1     = slot_q[1];
    assign out2     = slot_q[2];
    assign out3     = slot_q[3];
    assign out4     = slot_q[4];
    assign out5     = slot_q[5];
    assign out6     = slot_q[6];
    assign out7     = slot_q[7];
    assign position = position_q;
    assign editing  = (state_q == EDIT);
    assign digit    = digit_q;
    assign draft    = draft_q;
    assign wr_valid = wr_valid_q;
    assign wr_slot  = wr_slot_q;

endmodule

// File: tb/tb_input_menu.sv
// ---------------------------------------------------------------------------
// tb_input_menu
//
// Directed bench for input_menu. Each step drives the buttons for one clock,
// pushes the values the outputs must then hold onto a scoreboard queue, and
// pops/compares them after the edge.
// ---------------------------------------------------------------------------
module tb_input_menu;

    localparam int WIDTH = 24;

    typedef enum int {
        K_POS, K_EDIT, K_DIGIT, K_DRAFT, K_WRV, K_WRS,
        K_S0, K_S1, K_S2, K_S3, K_S4, K_S5, K_S6, K_S7
    } kind_t;

    typedef struct {
        string       tag;
        kind_t       kind;
        logic [31:0] val;
    } exp_t;

    logic             clk;
    logic             rst;
    logic [3:0]       button;
    logic [WIDTH-1:0] out0, out1, out2, out3, out4, out5, out6, out7;
    logic [2:0]       position;
    logic             editing;
    logic [2:0]       digit;
    logic [WIDTH-1:0] draft;
    logic             wr_valid;
    logic [2:0]       wr_slot;

    exp_t expQ[$];
    int   testCount = 0;
    int   failCount = 0;

    input_menu #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .button   (button),
        .out0     (out0),
        .out1     (out1),
        .out2     (out2),
        .out3     (out3),
        .out4     (out4),
        .out5     (out5),
        .out6     (out6),
        .out7     (out7),
        .position (position),
        .editing  (editing),
        .digit    (digit),
        .draft    (draft),
        .wr_valid (wr_valid),
        .wr_slot  (wr_slot)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one button pattern for exactly one rising edge and returns 1
    // time unit after that edge, which is where outputs get sampled.
    task automatic applyStimulus(input logic [3:0] b);
        button = b;
        @(posedge clk);
        #1;
    endtask

    task automatic expectVal(input string tag, input kind_t k, input logic [31:0] v);
        exp_t e;
        e.tag  = tag;
        e.kind = k;
        e.val  = v;
        expQ.push_back(e);
    endtask

    // Shorthand for the cursor/edit state after a step.
    task automatic expectState(input string tag, input logic [2:0] p, input logic e,
                               input logic [2:0] d, input logic [31:0] dr);
        expectVal({tag, ".pos"},   K_POS,   32'(p));
        expectVal({tag, ".edit"},  K_EDIT,  32'(e));
        expectVal({tag, ".digit"}, K_DIGIT, 32'(d));
        expectVal({tag, ".draft"}, K_DRAFT, dr);
    endtask

    task automatic expectSlots(input string tag, input logic [31:0] s [8]);
        for (int i = 0; i < 8; i++) begin
            expectVal($sformatf("%s.out%0d", tag, i), kind_t'(int'(K_S0) + i), s[i]);
        end
    endtask

    function automatic logic [31:0] observe(input kind_t k);
        case (k)
            K_POS:   return 32'(position);
            K_EDIT:  return 32'(editing);
            K_DIGIT: return 32'(digit);
            K_DRAFT: return 32'(draft);
            K_WRV:   return 32'(wr_valid);
            K_WRS:   return 32'(wr_slot);
            K_S0:    return 32'(out0);
            K_S1:    return 32'(out1);
            K_S2:    return 32'(out2);
            K_S3:    return 32'(out3);
            K_S4:    return 32'(out4);
            K_S5:    return 32'(out5);
            K_S6:    return 32'(out6);
            K_S7:    return 32'(out7);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Pops every queued expectation and compares it with the live outputs.
    task automatic checkOutput();
        exp_t        e;
        logic [31:0] obs;
        while (expQ.size() > 0) begin
            e   = expQ.pop_front();
            obs = observe(e.kind);
            testCount++;
            assert (obs === e.val) else begin
                failCount++;
                $display("[TB] FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
                $error("[TB] check %s observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    initial begin : stimulus
        logic [31:0] slots [8];
        for (int i = 0; i < 8; i++) slots[i] = 32'h0;

        // Reset with [0] held throughout.
        rst = 1'b0;
        applyStimulus(4'b0001);
        applyStimulus(4'b0001);
        expectState("reset", 3'd0, 1'b0, 3'd0, 32'h0);
        expectVal("reset.wrv", K_WRV, 32'h0);
        expectVal("reset.wrs", K_WRS, 32'h0);
        expectSlots("reset", slots);
        checkOutput();

        // Button held through reset must not move the cursor.
        rst = 1'b1;
        applyStimulus(4'b0001);
        expectVal("heldThroughReset.pos", K_POS, 32'd0);
        checkOutput();
        applyStimulus(4'b0000);

        applyStimulus(4'b0010);
        expectVal("next1.pos", K_POS, 32'd1);
        checkOutput();
        applyStimulus(4'b0000);
        applyStimulus(4'b0010);
        expectVal("next2.pos", K_POS, 32'd2);
        checkOutput();
        // Held for a second cycle: no repeat.
        applyStimulus(4'b0010);
        expectVal("heldNext.pos", K_POS, 32'd2);
        checkOutput();

        // Back-to-back edges on consecutive cycles: prev then next.
        applyStimulus(4'b0001);
        expectVal("b2bPrev.pos", K_POS, 32'd1);
        checkOutput();
        applyStimulus(4'b0010);
        expectVal("b2bNext.pos", K_POS, 32'd2);
        checkOutput();
        applyStimulus(4'b0000);

        // Walk back to 0, then wrap both ways.
        applyStimulus(4'b0001);
        applyStimulus(4'b0000);
        applyStimulus(4'b0001);
        expectVal("backTo0.pos", K_POS, 32'd0);
        checkOutput();
        applyStimulus(4'b0000);
        applyStimulus(4'b0001);
        expectVal("wrapDown.pos", K_POS, 32'd7);
        checkOutput();
        applyStimulus(4'b0000);
        applyStimulus(4'b0010);
        expectVal("wrapUp.pos", K_POS, 32'd0);
        checkOutput();
        applyStimulus(4'b0000);
        applyStimulus(4'b0011);
        expectVal("bothPrevNext.pos", K_POS, 32'd0);
        checkOutput();
        applyStimulus(4'b0000);

        // Commit in browse does nothing.
        applyStimulus(4'b1000);
        expectVal("browseCommit.wrv", K_WRV, 32'h0);
        expectVal("browseCommit.edit", K_EDIT, 32'h0);
        checkOutput();
        applyStimulus(4'b0000);

        // Move to slot 3 and edit it to 0x0000F3.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b0010);
            applyStimulus(4'b0000);
        end
        applyStimulus(4'b0100);
        expectState("enterEdit3", 3'd3, 1'b1, 3'd0, 32'h0);
        checkOutput();
        applyStimulus(4'b0000);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b0010);
            applyStimulus(4'b0000);
        end
        expectState("inc3", 3'd3, 1'b1, 3'd0, 32'h000003);
        checkOutput();
        applyStimulus(4'b0100);
        expectVal("advance.digit", K_DIGIT, 32'd1);
        checkOutput();
        applyStimulus(4'b0000);
        applyStimulus(4'b0001);
        expectState("decDigit1", 3'd3, 1'b1, 3'd1, 32'h0000F3);
        checkOutput();
        applyStimulus(4'b0000);
        applyStimulus(4'b1000);
        slots[3] = 32'h0000F3;
        expectState("commit3", 3'd3, 1'b0, 3'd1, 32'h0000F3);
        expectVal("commit3.wrv", K_WRV, 32'h1);
        expectVal("commit3.wrs", K_WRS, 32'd3);
        expectSlots("commit3", slots);
        checkOutput();
        applyStimulus(4'b0000);
        expectVal("commit3After.wrv", K_WRV, 32'h0);
        expectSlots("commit3After", slots);
        checkOutput();

        // Slot 0: draft loads from the slot, nibble wraps without borrow/carry.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b0001);
            applyStimulus(4'b0000);
        end
        applyStimulus(4'b0100);
        expectState("enterEdit0", 3'd0, 1'b1, 3'd0, 32'h0);
        checkOutput();
        applyStimulus(4'b0000);
        applyStimulus(4'b0001);
        expectVal("decWrap.draft", K_DRAFT, 32'h00000F);
        checkOutput();
        applyStimulus(4'b0000);
        applyStimulus(4'b0010);
        expectVal("incWrap.draft", K_DRAFT, 32'h000000);
        checkOutput();
        applyStimulus(4'b0000);
        applyStimulus(4'b0001);
        applyStimulus(4'b0000);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'b0100);
            applyStimulus(4'b0000);
        end
        expectVal("digit5.digit", K_DIGIT, 32'd5);
        checkOutput();
        applyStimulus(4'b0100);
        expectState("digitWrap", 3'd0, 1'b1, 3'd0, 32'h00000F);
        checkOutput();
        applyStimulus(4'b0000);

        // Reset mid-edit discards the draft and clears the slots.
        rst = 1'b0;
        applyStimulus(4'b0000);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) slots[i] = 32'h0;
        expectState("midEditReset", 3'd0, 1'b0, 3'd0, 32'h0);
        expectVal("midEditReset.wrv", K_WRV, 32'h0);
        expectVal("midEditReset.wrs", K_WRS, 32'h0);
        expectSlots("midEditReset", slots);
        checkOutput();
        applyStimulus(4'b0000);
        expectVal("afterReset.wrv", K_WRV, 32'h0);
        checkOutput();

        // Edit slot 0 to 1, then press edit and commit together.
        applyStimulus(4'b0100);
        applyStimulus(4'b0000);
        applyStimulus(4'b0010);
        expectState("preCombo", 3'd0, 1'b1, 3'd0, 32'h000001);
        checkOutput();
        applyStimulus(4'b0000);
        applyStimulus(4'b1100);
`ifdef INPUT_MENU_CANCEL_EN
        expectState("cancel", 3'd0, 1'b0, 3'd0, 32'h000001);
        expectVal("cancel.wrv", K_WRV, 32'h0);
`else
        slots[0] = 32'h000001;
        expectState("comboCommit", 3'd0, 1'b0, 3'd0, 32'h000001);
        expectVal("comboCommit.wrv", K_WRV, 32'h1);
        expectVal("comboCommit.wrs", K_WRS, 32'd0);
`endif
        expectSlots("combo", slots);
        checkOutput();
        applyStimulus(4'b0000);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
